out_display_seq: RTL and testbench
==================================

# out_display_seq

Sequential display driver between the processor's output port (`OUT` value, `flagOUT` strobe) and the four 7-segment digits. It captures a signed 32-bit value on each output strobe and converts its magnitude to BCD iteratively with shift-add-3 (double dabble). It then registers segment patterns for a sign digit plus hundreds, tens and ones digits. A one-deep pending buffer absorbs strobes that arrive while a conversion is in flight.

## Interface
- `BLANK_ZEROS`, default 0: when 1, leading zero hundreds/tens digits are shown blank; the ones digit is never blanked.
- `clock` input 1: system clock, the divided processor clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `flagOUT` input 1: output strobe; `Value` is valid in any cycle where it is high.
- `Value` input 32: signed two's-complement value to display.
- `OUT_N` output 7: sign digit segments.
- `OUT_H` output 7: hundreds digit segments.
- `OUT_T` output 7: tens digit segments.
- `OUT_O` output 7: ones digit segments.
- `busy` output 1: conversion in progress.
- `overflow` output 1: the last displayed value was outside -999..999.

## Operation
- Segment encoding:
  - Active-low, bit order {g,f,e,d,c,b,a}.
  - Digits 0–9: 0x40, 0x79, 0x24, 0x30, 0x19, 0x12, 0x02, 0x78, 0x00, 0x10.
  - Dash: 0x3F. Blank: 0x7F.
- States: IDLE, CONVERT, UPDATE.
- Capture (leaving IDLE):
  - Source is `Value` if `flagOUT` is high, else the pending register if pending is set. `flagOUT` has priority; pending is cleared either way.
  - Latch sign = source[31] and magnitude = |source| as 32-bit unsigned. -2^31 gives magnitude 2^31.
  - Latch ovf = (magnitude > 999).
  - Load shift register with magnitude[9:0]; clear BCD to 0; iteration counter to 0; next state CONVERT.
- CONVERT:
  - Each cycle, every BCD nibble >= 5 gets +3.
  - Then {BCD[11:0], shift[9:0]} shifts left one bit and the counter increments.
  - After exactly 10 iterations, next state is UPDATE.
- UPDATE: registers the outputs, then returns to IDLE.
  - If ovf: all four outputs show dash; `overflow` is set to 1.
  - Otherwise `overflow` is set to 0 and the digits are:
    - `OUT_N` shows dash if sign is 1 and magnitude != 0, else blank.
    - `OUT_H`, `OUT_T`, `OUT_O` show BCD[11:8], [7:4], [3:0].
    - With `BLANK_ZEROS`=1: hundreds is blank if 0; tens is blank if hundreds and tens are both 0.
- Pending buffer:
  - `flagOUT` high in CONVERT or UPDATE stores `Value` into the pending register and sets pending.
  - A later strobe overwrites the earlier one; only the newest value is kept.
- Segment outputs and `overflow` change only on the UPDATE edge.

## Timing
- Reset values (async, immediate):
  - State IDLE; pending 0; `busy` 0; `overflow` 0.
  - `OUT_N`/`OUT_H`/`OUT_T`/`OUT_O` = 0x7F (blank).
- `flagOUT` sampled high in IDLE at edge k:
  - `busy` rises at edge k.
  - CONVERT occupies edges k+1..k+10.
  - Outputs update and `busy` falls at edge k+11.
  - Latency is 11 cycles.
- Pending set at return to IDLE: the capture occurs at the next edge (k+12), so back-to-back conversions take 12 cycles each.
- `flagOUT` held high continuously: reconverts every 12 cycles with the newest value.
- Reset asserted mid-CONVERT: the conversion is abandoned, outputs go blank, and pending is cleared. After release, nothing is displayed until the next strobe.
- `busy` is registered from state (high in CONVERT and UPDATE).

## Test plan
- Reset, then `flagOUT`=1 for one cycle with `Value`=123 → at +11 edges: `OUT_N`=0x7F, `OUT_H`=0x79, `OUT_T`=0x24, `OUT_O`=0x30; `busy` high for exactly 11 cycles.
- `Value`=-45 → `OUT_N`=0x3F, `OUT_H`=0x40, `OUT_T`=0x19, `OUT_O`=0x12. Repeat with `BLANK_ZEROS`=1 → `OUT_H`=0x7F.
- `Value`=1000, then `Value`=0x80000000 → all digits 0x3F and `overflow`=1. Then `Value`=999 → digits 0x10 and `overflow`=0.
- Strobe 7, then strobes 8 and 9 at +3 and +5 cycles → display shows 7 at +11 and 9 at +23; 8 is never displayed.
- Strobe 0 with `BLANK_ZEROS`=0 → 0x7F, 0x40, 0x40, 0x40. Strobe 555, then reset at +5 → all outputs 0x7F, `busy` 0; no update after reset release.

Source files
------------

// File: rtl/out_display_seq.sv
// out_display_seq: registers a signed strobed value and converts its magnitude to BCD with
// double dabble, one bit per cycle. It then drives four active-low 7-segment digits: sign,
// hundreds, tens and ones. A one-deep pending buffer keeps the newest strobe that arrives
// while a conversion is in progress.
module out_display_seq #(
  parameter bit BLANK_ZEROS = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flagOUT,
  input  logic [31:0] Value,
  output logic [6:0]  OUT_N,
  output logic [6:0]  OUT_H,
  output logic [6:0]  OUT_T,
  output logic [6:0]  OUT_O,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHIFT_W = 10;
  localparam int unsigned BCD_W   = 12;
  localparam int unsigned DD_W    = BCD_W + SHIFT_W;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned ITERS   = 10;
  localparam int unsigned MAX_MAG = 999;

  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    UPDATE
  } state_t;

  state_t              state;
  logic                pending;
  logic [DATA_W-1:0]   pend_val;
  logic                sign_neg;
  logic                ovf;
  logic [DD_W-1:0]     dd_q;      // {bcd[11:0], shift[9:0]}
  logic [CNT_W-1:0]    cnt_q;

  logic [DATA_W-1:0]   src_c;
  logic [DATA_W-1:0]   mag_c;
  logic [DD_W-1:0]     dd_adj_c;
  logic [6:0]          seg_h_c;
  logic [6:0]          seg_t_c;
  logic [6:0]          seg_o_c;

  // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Capture source selection and magnitude; a fresh strobe beats the pending value
  always_comb begin
    src_c = flagOUT ? Value : pend_val;
    mag_c = src_c[DATA_W-1] ? DATA_W'(-src_c) : src_c;
  end

  // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift
  always_comb begin
    dd_adj_c = dd_q;
    for (int i = 0; i < 3; i++) begin
      if (dd_q[SHIFT_W + 4*i +: 4] >= 4'd5) begin
        dd_adj_c[SHIFT_W + 4*i +: 4] = dd_q[SHIFT_W + 4*i +: 4] + 4'd3;
      end
    end
  end

  // Digit patterns from the finished BCD, with optional leading-zero blanking
  always_comb begin
    seg_h_c = seg7(dd_q[SHIFT_W + 8 +: 4]);
    seg_t_c = seg7(dd_q[SHIFT_W + 4 +: 4]);
    seg_o_c = seg7(dd_q[SHIFT_W +: 4]);
    if (BLANK_ZEROS && (dd_q[SHIFT_W + 8 +: 4] == 4'd0)) begin
      seg_h_c = SEG_BLANK;
    end
    if (BLANK_ZEROS && (dd_q[SHIFT_W + 4 +: 8] == 8'd0)) begin
      seg_t_c = SEG_BLANK;
    end
  end

  // Control FSM, conversion datapath, pending buffer and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pending  <= 1'b0;
      pend_val <= '0;
      sign_neg <= 1'b0;
      ovf      <= 1'b0;
      dd_q     <= '0;
      cnt_q    <= '0;
      OUT_N    <= SEG_BLANK;
      OUT_H    <= SEG_BLANK;
      OUT_T    <= SEG_BLANK;
      OUT_O    <= SEG_BLANK;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flagOUT || pending) begin
            sign_neg <= src_c[DATA_W-1] && (mag_c != '0);
            ovf      <= (mag_c > DATA_W'(MAX_MAG));
            dd_q     <= {BCD_W'(0), mag_c[SHIFT_W-1:0]};
            cnt_q    <= '0;
            pending  <= 1'b0;
            busy     <= 1'b1;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          dd_q  <= dd_adj_c << 1;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITERS - 1)) begin
            state <= UPDATE;
          end
        end
        UPDATE: begin
          if (ovf) begin
            OUT_N    <= SEG_DASH;
            OUT_H    <= SEG_DASH;
            OUT_T    <= SEG_DASH;
            OUT_O    <= SEG_DASH;
            overflow <= 1'b1;
          end else begin
            OUT_N    <= sign_neg ? SEG_DASH : SEG_BLANK;
            OUT_H    <= seg_h_c;
            OUT_T    <= seg_t_c;
            OUT_O    <= seg_o_c;
            overflow <= 1'b0;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase

      // Strobes during a conversion overwrite the single pending slot
      if (flagOUT && (state != IDLE)) begin
        pending  <= 1'b1;
        pend_val <= Value;
      end
    end
  end

endmodule

// File: tb/tb_out_display_seq.sv
// Testbench for out_display_seq: directed scenarios plus randomized strobe traffic checked
// against a cycle-interval reference model, on two instances (BLANK_ZEROS = 0 and 1).
module tb_out_display_seq;

  logic        clock;
  logic        reset;
  logic        flagOUT;
  logic [31:0] Value;

  logic [6:0] n0, h0, t0, o0, n1, h1, t1, o1;
  logic       busy0, busy1, ov0, ov1;
  logic [28:0] obs0, obs1;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [28:0] BLANK_DISP = {1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  localparam logic [28:0] DASH_DISP  = {1'b1, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  logic [6:0]  seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [31:0] edge_vals [8] = '{32'd999, 32'hFFFF_FC19, 32'd1000, 32'hFFFF_FC18,
                                 32'd0, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};

  out_display_seq #(.BLANK_ZEROS(1'b0)) dut0 (
    .clock(clock), .reset(reset), .flagOUT(flagOUT), .Value(Value),
    .OUT_N(n0), .OUT_H(h0), .OUT_T(t0), .OUT_O(o0), .busy(busy0), .overflow(ov0)
  );

  out_display_seq #(.BLANK_ZEROS(1'b1)) dut1 (
    .clock(clock), .reset(reset), .flagOUT(flagOUT), .Value(Value),
    .OUT_N(n1), .OUT_H(h1), .OUT_T(t1), .OUT_O(o1), .busy(busy1), .overflow(ov1)
  );

  assign obs0 = {ov0, n0, h0, t0, o0};
  assign obs1 = {ov1, n1, h1, t1, o1};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected {overflow, N, H, T, O} for a value, straight from decimal arithmetic
  function automatic logic [28:0] model_disp(input logic [31:0] v, input bit bz);
    longint sv, m;
    int h, t, o;
    logic [6:0] ns, hs, ts, os;
    sv = longint'($signed(v));
    m  = (sv < 0) ? -sv : sv;
    if (m > 999) return DASH_DISP;
    h  = int'(m / 100);
    t  = int'((m / 10) % 10);
    o  = int'(m % 10);
    ns = (sv < 0) ? 7'h3F : 7'h7F;
    hs = seg_tab[h];
    ts = seg_tab[t];
    os = seg_tab[o];
    if (bz && h == 0) hs = 7'h7F;
    if (bz && h == 0 && t == 0) ts = 7'h7F;
    return {1'b0, ns, hs, ts, os};
  endfunction

  function automatic logic [31:0] rand_val();
    int r;
    r = int'($urandom_range(0, 999));
    case ($urandom % 4)
      0: return 32'(r);
      1: return 32'(-r);
      2: return $urandom;
      default: return edge_vals[$urandom % 8];
    endcase
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flagOUT = 1'b0;
    step();
    reset = 1'b0;
    step();
  endtask

  // One-cycle strobe, then wait (bounded) for busy to drop; returns busy-high cycle count
  task automatic drive_and_wait(input logic [31:0] v, output int cyc);
    flagOUT = 1'b1;
    Value   = v;
    step();
    flagOUT = 1'b0;
    Value   = $urandom;
    cyc = 0;
    while (busy0 === 1'b1 && cyc < 40) begin
      cyc++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flagOUT = 1'b0;
    Value = 32'd0;
    step();
    step();
    n_tests++;
    if (obs0 !== BLANK_DISP) begin n_fail++; $display("FAIL reset_disp0: got %h expected %h", obs0, BLANK_DISP); end
    n_tests++;
    if (obs1 !== BLANK_DISP) begin n_fail++; $display("FAIL reset_disp1: got %h expected %h", obs1, BLANK_DISP); end
    n_tests++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b%b expected 00", busy0, busy1); end
    reset = 1'b0;
    step();
    n_tests++;
    if (obs0 !== BLANK_DISP || busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got %h/%b expected %h/0", obs0, busy0, BLANK_DISP); end
  endtask

  task automatic test_basic();
    logic [28:0] exp;
    exp = {1'b0, 7'h7F, 7'h79, 7'h24, 7'h30};
    flagOUT = 1'b1;
    Value = 32'd123;
    step();
    flagOUT = 1'b0;
    for (int c = 0; c < 11; c++) begin
      n_tests++;
      if (busy0 !== 1'b1 || obs0 !== BLANK_DISP) begin
        n_fail++; $display("FAIL basic_hold_c%0d: got busy=%b disp=%h expected busy=1 disp=%h", c, busy0, obs0, BLANK_DISP);
      end
      step();
    end
    n_tests++;
    if (busy0 !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall: got %b expected 0", busy0); end
    n_tests++;
    if (obs0 !== exp) begin n_fail++; $display("FAIL basic_123: got %h expected %h", obs0, exp); end
  endtask

  task automatic test_negative();
    int cyc;
    logic [28:0] e0, e1;
    e0 = {1'b0, 7'h3F, 7'h40, 7'h19, 7'h12};
    e1 = {1'b0, 7'h3F, 7'h7F, 7'h19, 7'h12};
    drive_and_wait(32'hFFFF_FFD3, cyc);
    n_tests++;
    if (cyc !== 11) begin n_fail++; $display("FAIL neg_latency: got %0d expected 11", cyc); end
    n_tests++;
    if (obs0 !== e0) begin n_fail++; $display("FAIL neg45_bz0: got %h expected %h", obs0, e0); end
    n_tests++;
    if (obs1 !== e1) begin n_fail++; $display("FAIL neg45_bz1: got %h expected %h", obs1, e1); end
  endtask

  task automatic test_overflow();
    int cyc;
    logic [28:0] e999;
    e999 = {1'b0, 7'h7F, 7'h10, 7'h10, 7'h10};
    drive_and_wait(32'd1000, cyc);
    n_tests++;
    if (obs0 !== DASH_DISP) begin n_fail++; $display("FAIL ovf_1000: got %h expected %h", obs0, DASH_DISP); end
    drive_and_wait(32'h8000_0000, cyc);
    n_tests++;
    if (obs0 !== DASH_DISP || obs1 !== DASH_DISP) begin n_fail++; $display("FAIL ovf_min: got %h/%h expected %h", obs0, obs1, DASH_DISP); end
    drive_and_wait(32'd999, cyc);
    n_tests++;
    if (obs0 !== e999) begin n_fail++; $display("FAIL ovf_999: got %h expected %h", obs0, e999); end
  endtask

  task automatic test_pending();
    logic [28:0] e7, e8, e9;
    bit seen8;
    e7 = {1'b0, 7'h7F, 7'h40, 7'h40, 7'h78};
    e8 = {1'b0, 7'h7F, 7'h40, 7'h40, 7'h00};
    e9 = {1'b0, 7'h7F, 7'h40, 7'h40, 7'h10};
    seen8 = 1'b0;
    flagOUT = 1'b1;
    Value = 32'd7;
    step();
    for (int c = 1; c <= 26; c++) begin
      flagOUT = (c == 3 || c == 5);
      Value = (c == 3) ? 32'd8 : (c == 5) ? 32'd9 : $urandom;
      step();
      if (obs0 === e8) seen8 = 1'b1;
      if (c == 11) begin
        n_tests++;
        if (obs0 !== e7) begin n_fail++; $display("FAIL pend_show7: got %h expected %h", obs0, e7); end
      end
      if (c == 12) begin
        n_tests++;
        if (busy0 !== 1'b1) begin n_fail++; $display("FAIL pend_recapture: got %b expected 1", busy0); end
      end
      if (c == 23) begin
        n_tests++;
        if (obs0 !== e9) begin n_fail++; $display("FAIL pend_show9: got %h expected %h", obs0, e9); end
      end
    end
    n_tests++;
    if (seen8 !== 1'b0) begin n_fail++; $display("FAIL pend_drop8: got %b expected 0", seen8); end
    n_tests++;
    if (busy0 !== 1'b0) begin n_fail++; $display("FAIL pend_idle: got %b expected 0", busy0); end
  endtask

  task automatic test_zero();
    int cyc;
    logic [28:0] e0, e1;
    e0 = {1'b0, 7'h7F, 7'h40, 7'h40, 7'h40};
    e1 = {1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    drive_and_wait(32'd0, cyc);
    n_tests++;
    if (obs0 !== e0) begin n_fail++; $display("FAIL zero_bz0: got %h expected %h", obs0, e0); end
    n_tests++;
    if (obs1 !== e1) begin n_fail++; $display("FAIL zero_bz1: got %h expected %h", obs1, e1); end
  endtask

  task automatic test_reset_mid();
    bit changed;
    changed = 1'b0;
    flagOUT = 1'b1;
    Value = 32'd555;
    step();
    flagOUT = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    #1;
    n_tests++;
    if (obs0 !== BLANK_DISP || obs1 !== BLANK_DISP) begin n_fail++; $display("FAIL rstmid_blank: got %h/%h expected %h", obs0, obs1, BLANK_DISP); end
    n_tests++;
    if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy0); end
    step();
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (obs0 !== BLANK_DISP || busy0 !== 1'b0) changed = 1'b1;
    end
    n_tests++;
    if (changed !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet: got %b expected 0", changed); end
  endtask

  task automatic test_held();
    logic [31:0] vals [36];
    logic [28:0] e0, e1;
    do_reset();
    flagOUT = 1'b1;
    for (int c = 0; c < 36; c++) begin
      vals[c] = rand_val();
      Value = vals[c];
      step();
      if (c == 11 || c == 23 || c == 35) begin
        e0 = model_disp(vals[c - 11], 1'b0);
        e1 = model_disp(vals[c - 11], 1'b1);
        n_tests++;
        if (obs0 !== e0 || obs1 !== e1) begin
          n_fail++; $display("FAIL held_c%0d: got %h/%h expected %h/%h", c, obs0, obs1, e0, e1);
        end
      end
    end
    flagOUT = 1'b0;
    do_reset();
  endtask

  task automatic test_random_single();
    int cyc;
    logic [31:0] v;
    for (int i = 0; i < 20; i++) begin
      v = rand_val();
      drive_and_wait(v, cyc);
      n_tests++;
      if (cyc !== 11) begin n_fail++; $display("FAIL rand_latency v=%h: got %0d expected 11", v, cyc); end
      n_tests++;
      if (obs0 !== model_disp(v, 1'b0) || obs1 !== model_disp(v, 1'b1)) begin
        n_fail++; $display("FAIL rand_disp v=%h: got %h/%h expected %h/%h", v, obs0, obs1, model_disp(v, 1'b0), model_disp(v, 1'b1));
      end
    end
  endtask

  // Random strobe traffic; the model tracks only when the current conversion ends,
  // the newest pending value and which value was last shown
  task automatic test_random_burst();
    int busy_end;
    bit pend, shown, f;
    logic [31:0] pend_val, cur, shown_val, v;
    logic [28:0] e0, e1;
    logic exp_busy;
    do_reset();
    busy_end = -1;
    pend = 1'b0;
    shown = 1'b0;
    pend_val = '0;
    cur = '0;
    shown_val = '0;
    for (int c = 0; c < 300; c++) begin
      f = ($urandom % 4) == 0;
      v = rand_val();
      flagOUT = f;
      Value = v;
      step();
      if (c > busy_end) begin
        if (f) begin cur = v; busy_end = c + 11; pend = 1'b0; end
        else if (pend) begin cur = pend_val; busy_end = c + 11; pend = 1'b0; end
      end else if (f) begin
        pend = 1'b1;
        pend_val = v;
      end
      if (c == busy_end) begin shown = 1'b1; shown_val = cur; end
      exp_busy = (c < busy_end);
      e0 = shown ? model_disp(shown_val, 1'b0) : BLANK_DISP;
      e1 = shown ? model_disp(shown_val, 1'b1) : BLANK_DISP;
      n_tests++;
      if (obs0 !== e0) begin n_fail++; $display("FAIL burst_disp0_c%0d: got %h expected %h", c, obs0, e0); end
      n_tests++;
      if (obs1 !== e1) begin n_fail++; $display("FAIL burst_disp1_c%0d: got %h expected %h", c, obs1, e1); end
      n_tests++;
      if (busy0 !== exp_busy) begin n_fail++; $display("FAIL burst_busy_c%0d: got %b expected %b", c, busy0, exp_busy); end
    end
    flagOUT = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    flagOUT = 1'b0;
    Value = 32'd0;
    test_reset();
    test_basic();
    test_negative();
    test_overflow();
    test_pending();
    test_zero();
    test_reset_mid();
    test_held();
    test_random_single();
    test_random_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
